logit_argmax: RTL and testbench
===============================

// Module: logit_argmax
// PURPOSE
//   Output stage of the character RNN: consumes the VOCAB_SIZE logits streamed out by the
//   inference FSM (one signed Q8.8 word per beat) and selects the next token by greedy argmax.
//   Delivers the winning token index and its logit over a valid/ready handshake to the
//   token feedback / display logic, and flags malformed logit streams.
// PARAMETERS
//   VOCAB_SIZE   76  logits per sequence step; legal token indices 0..VOCAB_SIZE-1
//   DATA_WIDTH   16  logit width, signed two's complement Q8.8
//   TOKEN_WIDTH  7   token index width; requires 2**TOKEN_WIDTH >= VOCAB_SIZE
// PORTS
//   clk          in   1            system clock, all logic on rising edge
//   reset        in   1            asynchronous, active-low reset
//   start        in   1            pulse: begin a new scan (honoured only in IDLE)
//   logit_data   in   DATA_WIDTH   signed logit for current index
//   logit_valid  in   1            logit_data/logit_last valid
//   logit_last   in   1            marks final logit of the step
//   logit_ready  out  1            block accepts a logit this cycle
//   token_out    out  TOKEN_WIDTH  argmax index
//   max_logit    out  DATA_WIDTH   logit value at token_out
//   token_valid  out  1            token_out/max_logit/length_err valid
//   token_ready  in   1            consumer accepts result
//   length_err   out  1            stream length != VOCAB_SIZE for this result
//   busy         out  1            high in SCAN or RESULT
// BEHAVIOUR
//   Reset (async assert, sync deassert in practice): state=IDLE; all outputs 0; index=0;
//     best_val=most negative (0x8000); best_idx=0. Reset mid-scan/mid-result aborts, no output.
//   Beat = cycle with logit_valid && logit_ready. All outputs registered.
//   States:
//   IDLE:   logit_ready=0, token_valid=0. start=1 -> SCAN; on that edge index<=0,
//           best_val<=0x8000, best_idx<=0, length_err<=0.
//   SCAN:   logit_ready=1. Per beat: signed compare logit_data > best_val (strict) ->
//           best_val<=logit_data, best_idx<=index. Ties keep lowest index. index<=index+1.
//           Beat 0 always loads (0x8000 logit at index 0 still wins if all equal 0x8000).
//           End beat = beat with logit_last=1 OR index==VOCAB_SIZE-1; its logit is included
//           in the comparison; next state RESULT.
//           length_err<=1 if end beat has logit_last=1 with index!=VOCAB_SIZE-1, or
//           index==VOCAB_SIZE-1 with logit_last=0 (any trailing beats belong to caller; the
//           block is not ready for them).
//           Gaps in logit_valid: hold all state, no timeout.
//   RESULT: token_valid=1; token_out=best_idx, max_logit=best_val, length_err stable until
//           token_ready=1; on that edge token_valid<=0 -> IDLE. Same-cycle start ignored
//           (start honoured only in IDLE).
//   Latency: token_valid rises the cycle after the end beat (1 clk).
//   start while busy: ignored, no state change. busy=1 in SCAN and RESULT.
//   Index counter never exceeds VOCAB_SIZE-1; no wrap possible.
// TESTING
//   T1 logits i*0x0010 for i=0..75, last on 75 -> token_out=75, max_logit=0x04B0, err=0, 1-clk latency.
//   T2 all 76 logits =0x0100 -> token_out=0 (tie keeps lowest), max_logit=0x0100.
//   T3 all 0x8000 except idx 40=0xFFFF(-1/256), idx 41=0xFFFF -> token_out=40, max_logit=0xFFFF.
//   T4 random valid gaps + token_ready low 5 clks -> result held stable, single handshake, then IDLE.
//   T5 logit_last on beat 10 (idx 10) -> RESULT after 11 beats, length_err=1; start in RESULT ignored.
//   T6 reset low at beat 30 -> all outputs 0, IDLE; fresh scan after start gives correct argmax.

Source files
------------

// File: rtl/logit_argmax.sv
// Greedy argmax over one step of streamed logits from the character RNN.
// Accepts VOCAB_SIZE signed Q8.8 logits (one per beat), tracks the running
// maximum (ties keep the lowest index) and hands the winning index and its
// logit to the consumer over a valid/ready handshake. A stream that ends
// early (logit_last before the final index) or runs to the final index
// without logit_last is flagged with length_err.
module logit_argmax #(
  parameter int VOCAB_SIZE  = 76,
  parameter int DATA_WIDTH  = 16,
  parameter int TOKEN_WIDTH = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic signed [DATA_WIDTH-1:0]  logit_data,
  input  logic                          logit_valid,
  input  logic                          logit_last,
  output logic                          logit_ready,
  output logic [TOKEN_WIDTH-1:0]        token_out,
  output logic signed [DATA_WIDTH-1:0]  max_logit,
  output logic                          token_valid,
  input  logic                          token_ready,
  output logic                          length_err,
  output logic                          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam logic [TOKEN_WIDTH-1:0]       LAST_IDX = TOKEN_WIDTH'(VOCAB_SIZE - 1);
  localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t state, state_nxt;

  logic [TOKEN_WIDTH-1:0]       index_p0;
  logic signed [DATA_WIDTH-1:0] best_val_p0;
  logic [TOKEN_WIDTH-1:0]       best_idx_p0;

  logic                         beat;
  logic                         at_last_idx;
  logic                         end_beat;
  logic                         take;
  logic signed [DATA_WIDTH-1:0] cand_val;
  logic [TOKEN_WIDTH-1:0]       cand_idx;

  // The first beat always loads so that an all-minimum stream still yields
  // index 0; after that only a strictly greater logit displaces the leader,
  // which keeps the lowest index on ties.
  function automatic logic takes_lead(input logic                         first,
                                      input logic signed [DATA_WIDTH-1:0] val,
                                      input logic signed [DATA_WIDTH-1:0] best);
    return first || (val > best);
  endfunction

  // Beat qualification and the running-max candidate including this beat.
  always_comb begin
    beat        = logit_valid && logit_ready && (state == SCAN);
    at_last_idx = (index_p0 == LAST_IDX);
    end_beat    = beat && (logit_last || at_last_idx);
    take        = takes_lead(index_p0 == '0, logit_data, best_val_p0);
    cand_val    = take ? logit_data : best_val_p0;
    cand_idx    = take ? index_p0   : best_idx_p0;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)       state_nxt = SCAN;
      SCAN:    if (end_beat)    state_nxt = RESULT;
      RESULT:  if (token_ready) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Registered handshake/status outputs follow the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      logit_ready <= 1'b0;
      token_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      logit_ready <= (state_nxt == SCAN);
      token_valid <= (state_nxt == RESULT);
      busy        <= (state_nxt != IDLE);
    end
  end

  // Scan datapath: index counter and running maximum, cleared on start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index_p0    <= '0;
      best_val_p0 <= MOST_NEG;
      best_idx_p0 <= '0;
    end else if (state == IDLE && start) begin
      index_p0    <= '0;
      best_val_p0 <= MOST_NEG;
      best_idx_p0 <= '0;
    end else if (beat) begin
      best_val_p0 <= cand_val;
      best_idx_p0 <= cand_idx;
      // Stop counting at the final index so the counter can never wrap.
      if (!at_last_idx) index_p0 <= index_p0 + TOKEN_WIDTH'(1);
    end
  end

  // Result registers: captured on the end beat, held through RESULT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      token_out  <= '0;
      max_logit  <= '0;
      length_err <= 1'b0;
    end else if (state == IDLE && start) begin
      length_err <= 1'b0;
    end else if (end_beat) begin
      token_out  <= cand_idx;
      max_logit  <= cand_val;
      // Error when logit_last and the final index disagree.
      length_err <= logit_last ^ at_last_idx;
    end
  end

endmodule

// File: tb/tb_logit_argmax.sv
// Directed bench for logit_argmax: hand-computed argmax results for a set of
// logit streams, plus handshake, length-error and reset-abort scenarios.
module tb_logit_argmax;

  logic               clk;
  logic               reset;
  logic               start;
  logic signed [15:0] logit_data;
  logic               logit_valid;
  logic               logit_last;
  logic               logit_ready;
  logic [6:0]         token_out;
  logic signed [15:0] max_logit;
  logic               token_valid;
  logic               token_ready;
  logic               length_err;
  logic               busy;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] logits [0:75];

  logit_argmax #(.VOCAB_SIZE(76), .DATA_WIDTH(16), .TOKEN_WIDTH(7)) dut (
    .clk(clk), .reset(reset), .start(start),
    .logit_data(logit_data), .logit_valid(logit_valid), .logit_last(logit_last),
    .logit_ready(logit_ready), .token_out(token_out), .max_logit(max_logit),
    .token_valid(token_valid), .token_ready(token_ready),
    .length_err(length_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<2000000", $time);
    $fatal(1, "watchdog");
  end

  // Drive n beats; logit_last asserted on beat last_at (-1 = never).
  // With gaps, an idle cycle precedes every beat with i%5==2, and a stray
  // start pulse is driven on beat 4 (must be ignored mid-scan).
  task automatic send(input int n, input int last_at, input bit gaps);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (gaps && (i % 5 == 2)) begin
        logit_valid = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (logit_ready !== 1'b1 || token_valid !== 1'b0) begin
          errors++;
          $display("FAIL gap_hold beat %0d: ready=%b valid=%b required ready=1 valid=0", i, logit_ready, token_valid);
        end
        @(negedge clk);
      end
      checks++;
      if (logit_ready !== 1'b1) begin
        errors++;
        $display("FAIL beat_ready beat %0d: logit_ready=%b required 1", i, logit_ready);
      end
      if (i == n - 1) begin
        checks++;
        if (token_valid !== 1'b0) begin
          errors++;
          $display("FAIL early_valid: token_valid=%b required 0 before end beat", token_valid);
        end
      end
      logit_valid = 1'b1;
      logit_data  = logits[i];
      logit_last  = (i == last_at);
      start       = gaps && (i == 4);
      @(posedge clk);
    end
    #1;
  endtask

  task automatic start_scan();
    @(negedge clk);
    logit_valid = 1'b0; logit_last = 1'b0; token_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (logit_ready !== 1'b1 || busy !== 1'b1 || token_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_scan: ready=%b busy=%b valid=%b required 1 1 0", logit_ready, busy, token_valid);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic handshake();
    @(negedge clk);
    logit_valid = 1'b0; logit_last = 1'b0; start = 1'b0;
    token_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (token_valid !== 1'b0 || busy !== 1'b0 || logit_ready !== 1'b0) begin
      errors++;
      $display("FAIL handshake_idle: valid=%b busy=%b ready=%b required 0 0 0", token_valid, busy, logit_ready);
    end
    @(negedge clk);
    token_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; logit_valid = 1'b0; logit_last = 1'b0;
    logit_data = '0; token_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({token_valid, logit_ready, busy, length_err} !== 4'b0000 || token_out !== 7'd0 || max_logit !== 16'sh0000) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b ready=%b busy=%b err=%b tok=%0d max=%h required all 0",
               token_valid, logit_ready, busy, length_err, token_out, max_logit);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || logit_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: busy=%b ready=%b required 0 0", busy, logit_ready);
    end
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 76; i++) logits[i] = 16'(i * 16);
    start_scan();
    send(76, 75, 1'b0);
    checks++;
    if (token_valid !== 1'b1 || token_out !== 7'd75 || max_logit !== 16'sh04B0 || length_err !== 1'b0) begin
      errors++;
      $display("FAIL ramp: valid=%b tok=%0d max=%h err=%b required 1 75 04b0 0", token_valid, token_out, max_logit, length_err);
    end
    checks++;
    if (logit_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ramp_result_state: ready=%b busy=%b required 0 1", logit_ready, busy);
    end
    handshake();
  endtask

  task automatic test_ties();
    for (int i = 0; i < 76; i++) logits[i] = 16'sh0100;
    start_scan();
    send(76, 75, 1'b0);
    checks++;
    if (token_valid !== 1'b1 || token_out !== 7'd0 || max_logit !== 16'sh0100 || length_err !== 1'b0) begin
      errors++;
      $display("FAIL ties: valid=%b tok=%0d max=%h err=%b required 1 0 0100 0", token_valid, token_out, max_logit, length_err);
    end
    handshake();
  endtask

  task automatic test_negative();
    for (int i = 0; i < 76; i++) logits[i] = 16'sh8000;
    logits[40] = 16'shFFFF;
    logits[41] = 16'shFFFF;
    start_scan();
    send(76, 75, 1'b0);
    checks++;
    if (token_out !== 7'd40 || max_logit !== 16'shFFFF || length_err !== 1'b0) begin
      errors++;
      $display("FAIL negative: tok=%0d max=%h err=%b required 40 ffff 0", token_out, max_logit, length_err);
    end
    handshake();
  endtask

  task automatic test_all_min();
    for (int i = 0; i < 76; i++) logits[i] = 16'sh8000;
    start_scan();
    send(76, 75, 1'b0);
    checks++;
    if (token_out !== 7'd0 || max_logit !== 16'sh8000 || token_valid !== 1'b1) begin
      errors++;
      $display("FAIL all_min: tok=%0d max=%h valid=%b required 0 8000 1", token_out, max_logit, token_valid);
    end
    handshake();
  endtask

  task automatic test_gaps_backpressure();
    for (int i = 0; i < 76; i++) logits[i] = (i % 2 == 1) ? 16'(-(i * 16)) : 16'(i * 8);
    logits[57] = 16'sh7FFF;
    logits[60] = 16'sh7FFF;
    start_scan();
    send(76, 75, 1'b1);
    checks++;
    if (token_valid !== 1'b1 || token_out !== 7'd57 || max_logit !== 16'sh7FFF || length_err !== 1'b0) begin
      errors++;
      $display("FAIL gaps_result: valid=%b tok=%0d max=%h err=%b required 1 57 7fff 0", token_valid, token_out, max_logit, length_err);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      logit_valid = 1'b0; logit_last = 1'b0; start = 1'b0; token_ready = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (token_valid !== 1'b1 || token_out !== 7'd57 || max_logit !== 16'sh7FFF || length_err !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable cycle %0d: valid=%b tok=%0d max=%h err=%b required 1 57 7fff 0",
                 k, token_valid, token_out, max_logit, length_err);
      end
    end
    handshake();
    @(posedge clk); #1;
    checks++;
    if (token_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_handshake: valid=%b busy=%b required 0 0", token_valid, busy);
    end
  endtask

  task automatic test_short_stream();
    for (int i = 0; i < 76; i++) logits[i] = 16'shFF00;
    logits[3] = 16'sh0050;
    logits[7] = 16'sh0050;
    start_scan();
    send(11, 10, 1'b0);
    checks++;
    if (token_valid !== 1'b1 || token_out !== 7'd3 || max_logit !== 16'sh0050 || length_err !== 1'b1) begin
      errors++;
      $display("FAIL short_stream: valid=%b tok=%0d max=%h err=%b required 1 3 0050 1", token_valid, token_out, max_logit, length_err);
    end
    @(negedge clk);
    logit_valid = 1'b0; logit_last = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (token_valid !== 1'b1 || busy !== 1'b1 || logit_ready !== 1'b0 || token_out !== 7'd3 || length_err !== 1'b1) begin
      errors++;
      $display("FAIL start_in_result: valid=%b busy=%b ready=%b tok=%0d err=%b required 1 1 0 3 1",
               token_valid, busy, logit_ready, token_out, length_err);
    end
    @(negedge clk);
    start = 1'b1; token_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (token_valid !== 1'b0 || busy !== 1'b0 || logit_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_with_accept: valid=%b busy=%b ready=%b required 0 0 0", token_valid, busy, logit_ready);
    end
    @(negedge clk);
    start = 1'b0; token_ready = 1'b0;
  endtask

  task automatic test_no_last();
    for (int i = 0; i < 76; i++) logits[i] = 16'sh0000;
    logits[75] = 16'sh0123;
    start_scan();
    send(76, -1, 1'b0);
    checks++;
    if (token_valid !== 1'b1 || token_out !== 7'd75 || max_logit !== 16'sh0123 || length_err !== 1'b1 || logit_ready !== 1'b0) begin
      errors++;
      $display("FAIL no_last: valid=%b tok=%0d max=%h err=%b ready=%b required 1 75 0123 1 0",
               token_valid, token_out, max_logit, length_err, logit_ready);
    end
    handshake();
  endtask

  task automatic test_reset_mid_scan();
    for (int i = 0; i < 76; i++) logits[i] = 16'sh0000;
    logits[20] = 16'sh0200;
    start_scan();
    send(30, -1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({token_valid, logit_ready, busy, length_err} !== 4'b0000 || token_out !== 7'd0 || max_logit !== 16'sh0000) begin
      errors++;
      $display("FAIL reset_mid_scan: valid=%b ready=%b busy=%b err=%b tok=%0d max=%h required all 0",
               token_valid, logit_ready, busy, length_err, token_out, max_logit);
    end
    logit_valid = 1'b0; logit_last = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 76; i++) logits[i] = 16'shFFF0;
    logits[50] = 16'sh0300;
    start_scan();
    send(76, 75, 1'b0);
    checks++;
    if (token_valid !== 1'b1 || token_out !== 7'd50 || max_logit !== 16'sh0300 || length_err !== 1'b0) begin
      errors++;
      $display("FAIL rescan_after_reset: valid=%b tok=%0d max=%h err=%b required 1 50 0300 0",
               token_valid, token_out, max_logit, length_err);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_ties();
    test_negative();
    test_all_min();
    test_gaps_backpressure();
    test_short_stream();
    test_no_last();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
